// File: rtl/cache_fill_ctrl.sv
// Fill controller for a single-line, 32-byte cache: tag lookup, byte-wide line
// fetch streamed into the cache write port, and hit/miss response signalling.
module cache_fill_ctrl #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_valid,
    input  logic [7:0]        mem_data,
    output logic              cache_wren,
    output logic [7:0]        cache_data,
    output logic [4:0]        cache_wroffset,
    output logic [4:0]        cache_rdoffset,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned TAG_W = ADDR_W - 5;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIT,
        S_MREQ,
        S_FILL,
        S_SETTLE,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic             line_valid_q, line_valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] tag_req_q, tag_req_d;
    logic [4:0]       off_q, off_d;
    logic [4:0]       fill_cnt_q, fill_cnt_d;
    logic             resp_hit_q, resp_hit_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             lookup_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            line_valid_q <= 1'b0;
            tag_q        <= '0;
            tag_req_q    <= '0;
            off_q        <= '0;
            fill_cnt_q   <= '0;
            resp_hit_q   <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            line_valid_q <= line_valid_d;
            tag_q        <= tag_d;
            tag_req_q    <= tag_req_d;
            off_q        <= off_d;
            fill_cnt_q   <= fill_cnt_d;
            resp_hit_q   <= resp_hit_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // A simultaneous flush invalidates the line before the lookup, forcing a miss.
    assign lookup_hit = line_valid_q && !flush && (req_addr[ADDR_W-1:5] == tag_q);

    always_comb begin
        state_d        = state_q;
        line_valid_d   = line_valid_q;
        tag_d          = tag_q;
        tag_req_d      = tag_req_q;
        off_d          = off_q;
        fill_cnt_d     = fill_cnt_q;
        resp_hit_d     = resp_hit_q;
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_hit       = 1'b0;
        mem_req_valid  = 1'b0;
        mem_addr       = '0;
        cache_wren     = 1'b0;
        cache_data     = '0;
        cache_wroffset = '0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    tag_req_d = req_addr[ADDR_W-1:5];
                    off_d     = req_addr[4:0];
                    if (lookup_hit) begin
                        state_d    = S_HIT;
                        resp_hit_d = 1'b1;
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_ONE;
                    end else begin
                        state_d      = S_MREQ;
                        resp_hit_d   = 1'b0;
                        line_valid_d = 1'b0;
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_ONE;
                    end
                end else if (flush) begin
                    line_valid_d = 1'b0;
                end
            end
            S_HIT: begin
                state_d = S_RESP;
            end
            S_MREQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = {tag_req_q, 5'b00000};
                if (mem_req_ready) begin
                    state_d    = S_FILL;
                    fill_cnt_d = '0;
                end
            end
            S_FILL: begin
                cache_wren     = mem_data_valid;
                cache_data     = mem_data;
                cache_wroffset = fill_cnt_q;
                if (mem_data_valid) begin
                    fill_cnt_d = fill_cnt_q + 5'd1;
                    if (fill_cnt_q == 5'd31) begin
                        tag_d        = tag_req_q;
                        line_valid_d = 1'b1;
                        state_d      = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_hit   = resp_hit_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cache_rdoffset = off_q;
    assign hit_count      = hit_cnt_q;
    assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: table of requests, memory responder,
// cache RAM model, response scoreboard and multi-cycle corner sequences.
module tb_cache_fill_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        resp_valid;
    logic        resp_hit;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [7:0]  mem_data;
    logic        cache_wren;
    logic [7:0]  cache_data;
    logic [4:0]  cache_wroffset;
    logic [4:0]  cache_rdoffset;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    logic        req_ready_s, resp_valid_s, resp_hit_s, mem_req_valid_s, cache_wren_s;
    logic [15:0] mem_addr_s;
    logic [7:0]  cache_data_s;
    logic [4:0]  cache_wroffset_s, cache_rdoffset_s;
    logic [3:0]  hit_count_s, miss_count_s;

    cache_fill_ctrl #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .flush(flush), .resp_valid(resp_valid),
        .resp_hit(resp_hit), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .cache_wren(cache_wren), .cache_data(cache_data),
        .cache_wroffset(cache_wroffset), .cache_rdoffset(cache_rdoffset),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // Narrow-counter build sharing the same stimulus, used for saturation checks.
    cache_fill_ctrl #(.ADDR_W(16), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready_s), .flush(flush), .resp_valid(resp_valid_s),
        .resp_hit(resp_hit_s), .mem_req_valid(mem_req_valid_s),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr_s),
        .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .cache_wren(cache_wren_s), .cache_data(cache_data_s),
        .cache_wroffset(cache_wroffset_s), .cache_rdoffset(cache_rdoffset_s),
        .hit_count(hit_count_s), .miss_count(miss_count_s)
    );

    typedef struct {
        logic [15:0] addr;
        logic        fl;
        logic        hit;
        logic [7:0]  q;
    } vec_t;

    typedef struct {
        logic        hit;
        logic [7:0]  q;
        logic [4:0]  off;
        int unsigned acc;
    } exp_t;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned fetches = 0;
    int unsigned wr_pulses = 0;
    int unsigned exp_hits = 0;
    int unsigned exp_misses = 0;
    int unsigned stall_left = 0;
    logic        gap_mode = 1'b0;
    logic        gap_ph = 1'b0;
    logic        filling = 1'b0;
    logic [15:0] rbase = '0;
    logic [4:0]  ridx = '0;
    logic [4:0]  wofs = '0;
    logic [15:0] cur_base = '0;
    logic [7:0]  cram [32];
    exp_t        sb [$];
    exp_t        e;
    vec_t        vecs [8];

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        logic [7:0] t;
        t = a[12:5] - 8'h91;
        return 8'hA0 + {3'b000, a[4:0]} + t * 8'd3;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event did not occur as required", nm);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Cache RAM: falling-edge write, asynchronous read.
    always @(negedge clk) if (cache_wren) cram[cache_wroffset] <= cache_data;

    // Memory responder: drives just after the rising edge.
    initial begin
        mem_req_ready  = 1'b0;
        mem_data_valid = 1'b0;
        mem_data       = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            mem_req_ready  = 1'b0;
            mem_data_valid = 1'b0;
            if (rst) begin
                filling = 1'b0;
            end else if (filling) begin
                if (gap_mode && gap_ph) begin
                    gap_ph = 1'b0;
                end else begin
                    mem_data_valid = 1'b1;
                    mem_data = mem_byte(rbase | {11'b0, ridx});
                    ridx++;
                    gap_ph = 1'b1;
                    if (ridx == 5'd0) filling = 1'b0;
                end
            end else if (mem_req_valid) begin
                chk("mem_addr", 32'(mem_addr), 32'(cur_base));
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_req_ready = 1'b1;
                    filling = 1'b1;
                    rbase = mem_addr;
                    ridx = '0;
                    gap_ph = 1'b0;
                    fetches++;
                end
            end
        end
    end

    // Write-port monitor: offsets must run 0..31 and carry the fetched bytes.
    always @(negedge clk) begin
        if (!rst && cache_wren) begin
            chk("wroffset", 32'(cache_wroffset), 32'(wofs));
            chk("wrdata", 32'(cache_data), 32'(mem_byte(rbase | {11'b0, wofs})));
            wofs = wofs + 5'd1;
            wr_pulses++;
        end
    end

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                fail_now("resp_unexpected");
            end else begin
                e = sb.pop_front();
                chk("resp_hit", 32'(resp_hit), 32'(e.hit));
                chk("cache_q", 32'(cram[cache_rdoffset]), 32'(e.q));
                chk("rdoffset", 32'(cache_rdoffset), 32'(e.off));
                if (e.hit) chk("hit_latency", cyc - e.acc, 32'd2);
            end
        end
    end

    task automatic check_counts();
        chk("hit_count", 32'(hit_count), exp_hits);
        chk("miss_count", 32'(miss_count), exp_misses);
        chk("hit_count_sat", 32'(hit_count_s), (exp_hits > 15) ? 32'd15 : exp_hits);
        chk("miss_count_sat", 32'(miss_count_s), (exp_misses > 15) ? 32'd15 : exp_misses);
    endtask

    task automatic do_req(input logic [15:0] a, input logic fl, input logic eh, input logic [7:0] eq);
        int unsigned n;
        int unsigned f0;
        int unsigned w0;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) fail_now("req_ready_wait");
        f0 = fetches;
        w0 = wr_pulses;
        req_addr  = a;
        req_valid = 1'b1;
        flush     = fl;
        cur_base  = {a[15:5], 5'b00000};
        sb.push_back('{eh, eq, a[4:0], cyc});
        if (eh) exp_hits++;
        else exp_misses++;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("resp_timeout");
            sb.delete();
        end
        @(negedge clk);
        chk("resp_pulse_len", 32'(resp_valid), 32'd0);
        chk("fetch_count", fetches - f0, eh ? 32'd0 : 32'd1);
        chk("wren_pulses", wr_pulses - w0, eh ? 32'd0 : 32'd32);
        check_counts();
    endtask

    initial begin
        int unsigned n;
        int unsigned w0;

        vecs[0] = '{16'h1234, 1'b0, 1'b0, 8'hB4};
        vecs[1] = '{16'h123F, 1'b0, 1'b1, 8'hBF};
        vecs[2] = '{16'h1220, 1'b0, 1'b1, 8'hA0};
        vecs[3] = '{16'h5678, 1'b0, 1'b0, 8'h1E};
        vecs[4] = '{16'h1234, 1'b0, 1'b0, 8'hB4};
        vecs[5] = '{16'h1234, 1'b1, 1'b0, 8'hB4};
        vecs[6] = '{16'h1200, 1'b0, 1'b0, 8'h9D};
        vecs[7] = '{16'h121F, 1'b0, 1'b1, 8'hBC};

        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_cache_wren", 32'(cache_wren), 32'd0);
        chk("rst_rdoffset", 32'(cache_rdoffset), 32'd0);
        check_counts();

        for (int i = 0; i < 8; i++) do_req(vecs[i].addr, vecs[i].fl, vecs[i].hit, vecs[i].q);

        // Memory handshake stalled 5 cycles, fill strobes on every other cycle.
        stall_left = 5;
        gap_mode = 1'b1;
        do_req(16'h7000, 1'b0, 1'b0, 8'h6D);
        gap_mode = 1'b0;
        do_req(16'h7001, 1'b0, 1'b1, 8'h6E);

        // Reset after about 10 fill bytes: partial line discarded.
        w0 = wr_pulses;
        req_addr = 16'h1234;
        req_valid = 1'b1;
        cur_base = 16'h1220;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (wr_pulses < w0 + 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (wr_pulses < w0 + 10) fail_now("midfill_bytes");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wofs = '0;
        exp_hits = 0;
        exp_misses = 0;
        chk("mrst_req_ready", 32'(req_ready), 32'd1);
        chk("mrst_cache_wren", 32'(cache_wren), 32'd0);
        chk("mrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("mrst_rdoffset", 32'(cache_rdoffset), 32'd0);
        check_counts();
        do_req(16'h1234, 1'b0, 1'b0, 8'hB4);

        // Flush alone in IDLE, then flush together with the request.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        do_req(16'h1234, 1'b0, 1'b0, 8'hB4);
        do_req(16'h1234, 1'b1, 1'b0, 8'hB4);

        // 17 hits: narrow counter must stick at 15.
        for (int i = 0; i < 17; i++) begin
            do_req(16'h1220 + 16'(i), 1'b0, 1'b1, mem_byte(16'h1220 + 16'(i)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
